// File: rtl/xpb_lut_sched.sv
// Time-multiplexed XPB LUT sequencer: slices upper product bits into segments,
// issues one LUT read per cycle and accumulates the results. Optional: XPB_ZERO_SKIP_EN.
module xpb_lut_sched #(
  parameter int unsigned NUM_SEG     = 8,
  parameter int unsigned SEG_BITS    = 5,
  parameter int unsigned XPB_WIDTH   = 1024,
  parameter int unsigned LUT_LATENCY = 1,
  parameter int unsigned ACC_EXT     = $clog2(NUM_SEG)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_SEG*SEG_BITS-1:0]     upper_bits,
  output logic                            busy,
  output logic                            lut_req,
  output logic [$clog2(NUM_SEG)-1:0]      lut_seg,
  output logic [SEG_BITS-1:0]             lut_data_in,
  input  logic [XPB_WIDTH-1:0]            lut_data_out,
  output logic [XPB_WIDTH+ACC_EXT-1:0]    sum_out,
  output logic                            sum_valid,
  input  logic                            sum_ready
);

  localparam int unsigned SW   = $clog2(NUM_SEG);
  localparam int unsigned ACCW = XPB_WIDTH + ACC_EXT;
  localparam logic [LUT_LATENCY-1:0] TAIL_MASK = LUT_LATENCY'(1) << (LUT_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                       r_state, w_next;
  logic [NUM_SEG*SEG_BITS-1:0]  r_chunks;
  logic [ACCW-1:0]              r_acc;
  logic [LUT_LATENCY-1:0]       r_vsr;
  logic [SW-1:0]                w_issue_seg;
  logic                         w_found;
  logic                         w_issue_last;
  logic                         w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef XPB_ZERO_SKIP_EN
  logic [NUM_SEG-1:0] r_pend, w_pend_nz, w_pend_next;

  // Downward scan so the lowest pending index wins.
  always_comb begin
    w_pend_nz   = '0;
    w_issue_seg = '0;
    w_found     = 1'b0;
    for (int unsigned i = 0; i < NUM_SEG; i++)
      w_pend_nz[i] = |upper_bits[i*SEG_BITS +: SEG_BITS];
    for (int unsigned i = NUM_SEG; i > 0; i--) begin
      if (r_pend[i-1]) begin
        w_issue_seg = SW'(i - 1);
        w_found     = 1'b1;
      end
    end
    w_pend_next  = r_pend & ~(NUM_SEG'(1) << w_issue_seg);
    w_issue_last = (w_pend_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset)                    r_pend <= '0;
    else if (w_accept)            r_pend <= w_pend_nz;
    else if (r_state == S_ISSUE)  r_pend <= w_pend_next;
  end
`else
  logic [SW-1:0] r_seg;

  always_comb begin
    w_issue_seg  = r_seg;
    w_found      = 1'b1;
    w_issue_last = (r_seg == SW'(NUM_SEG - 1));
  end

  always_ff @(posedge clk) begin
    if (reset)                    r_seg <= '0;
    else if (w_accept)            r_seg <= '0;
    else if (r_state == S_ISSUE)  r_seg <= r_seg + 1'b1;
  end
`endif

  always_comb begin
    w_next      = r_state;
    busy        = (r_state != S_IDLE);
    lut_req     = 1'b0;
    lut_seg     = '0;
    lut_data_in = '0;
    sum_valid   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        lut_req = w_found;
        if (w_found) begin
          lut_seg     = w_issue_seg;
          lut_data_in = r_chunks[w_issue_seg*SEG_BITS +: SEG_BITS];
        end
        if (w_issue_last) w_next = S_DRAIN;
      end
      // Leave once only the tail remains: its add lands on the same edge.
      S_DRAIN: if ((r_vsr & ~TAIL_MASK) == '0) w_next = S_DONE;
      S_DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign sum_out = r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_chunks <= '0;
      r_acc    <= '0;
      r_vsr    <= '0;
    end else begin
      r_state  <= w_next;
      r_vsr[0] <= lut_req;
      for (int unsigned i = 1; i < LUT_LATENCY; i++)
        r_vsr[i] <= r_vsr[i-1];
      if (w_accept) begin
        r_chunks <= upper_bits;
        r_acc    <= '0;
      end else if (r_vsr[LUT_LATENCY-1]) begin
        r_acc <= r_acc + ACCW'(lut_data_out);
      end
    end
  end

endmodule

// File: tb/tb_xpb_lut_sched.sv
// Directed scoreboard bench for xpb_lut_sched (LUT_LATENCY 1 and 3 instances).
module tb_xpb_lut_sched;

  localparam int W    = 1024;
  localparam int ACCW = 1027;
`ifdef XPB_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_s, ready_s, sel, ones_mode;
  logic [39:0] bits;

  logic            busy0, req0, val0, busy1, req1, val1;
  logic [2:0]      seg0, seg1;
  logic [4:0]      din0, din1;
  logic [W-1:0]    dout0, dout1;
  logic [ACCW-1:0] sum0, sum1;

  logic [W-1:0] lat0;
  logic [W-1:0] lat1 [3];

  xpb_lut_sched #(.NUM_SEG(8), .SEG_BITS(5), .XPB_WIDTH(W), .LUT_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_s & ~sel), .upper_bits(bits),
    .busy(busy0), .lut_req(req0), .lut_seg(seg0), .lut_data_in(din0),
    .lut_data_out(dout0), .sum_out(sum0), .sum_valid(val0), .sum_ready(ready_s & ~sel));

  xpb_lut_sched #(.NUM_SEG(8), .SEG_BITS(5), .XPB_WIDTH(W), .LUT_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .start(start_s & sel), .upper_bits(bits),
    .busy(busy1), .lut_req(req1), .lut_seg(seg1), .lut_data_in(din1),
    .lut_data_out(dout1), .sum_out(sum1), .sum_valid(val1), .sum_ready(ready_s & sel));

  // LUT model: zero-extended chunk or all-ones; garbage when no request was made.
  function automatic logic [W-1:0] lut_f(input logic r, input logic [4:0] d);
    if (!r) return {32{32'hDEADBEEF}};
    return ones_mode ? {W{1'b1}} : W'(d);
  endfunction

  always @(posedge clk) begin
    lat0    <= lut_f(req0, din0);
    lat1[0] <= lut_f(req1, din1);
    lat1[1] <= lat1[0];
    lat1[2] <= lat1[1];
  end
  assign dout0 = lat0;
  assign dout1 = lat1[2];

  logic            v_busy, v_req, v_valid;
  logic [2:0]      v_seg;
  logic [4:0]      v_din;
  logic [ACCW-1:0] v_sum;
  assign v_busy  = sel ? busy1 : busy0;
  assign v_req   = sel ? req1  : req0;
  assign v_valid = sel ? val1  : val0;
  assign v_seg   = sel ? seg1  : seg0;
  assign v_din   = sel ? din1  : din0;
  assign v_sum   = sel ? sum1  : sum0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0]      q_seg [$];
  logic [ACCW-1:0] q_sum [$];

  task automatic chk(input string tag, input logic [ACCW-1:0] got, input logic [ACCW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h..%0h expected=%0h..%0h", tag,
             got[ACCW-1:ACCW-16], got[63:0], exp[ACCW-1:ACCW-16], exp[63:0]);
    end
  endtask

  // Called at a negedge with the selected DUT idle; that negedge is in cycle 0.
  task automatic run_job(input logic [39:0] b, input int exp_cyc, input logic [ACCW-1:0] exp_sum,
                         input int hold, input bit rdy_early, input bit skip_zero);
    logic [4:0] d;
    logic [7:0] e;
    bit         got;
    for (int i = 0; i < 8; i++) begin
      d = b[i*5 +: 5];
      if (!skip_zero || d != 5'd0) q_seg.push_back({3'(i), d});
    end
    q_sum.push_back(exp_sum);
    bits    = b;
    start_s = 1'b1;
    ready_s = rdy_early;
    got     = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_s = 1'b0;
        bits    = 40'({$urandom(), $urandom()});
      end
      if (v_req) begin
        if (q_seg.size() == 0) chk("spurious_req", v_req, 1'b0);
        else begin
          e = q_seg.pop_front();
          chk("lut_seg", v_seg, e[7:5]);
          chk("lut_data_in", v_din, e[4:0]);
        end
      end
      if (v_valid) begin
        got = 1'b1;
        chk("valid_cycle", c, exp_cyc);
        chk("sum_out", v_sum, q_sum.pop_front());
      end
    end
    if (!got) chk("valid_timeout", v_valid, 1'b1);
    chk("issues_left", q_seg.size(), 0);
    q_seg.delete();
    q_sum.delete();
    if (!rdy_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        start_s = (h == 2);
        chk("hold_valid", v_valid, 1'b1);
        chk("hold_sum", v_sum, exp_sum);
      end
      start_s = 1'b1;
      ready_s = 1'b1;
    end
    @(negedge clk);
    start_s = 1'b0;
    ready_s = 1'b0;
    chk("idle_busy", v_busy, 1'b0);
    chk("idle_valid", v_valid, 1'b0);
    @(negedge clk);
    chk("idle2_busy", v_busy, 1'b0);
  endtask

  initial begin
    logic [39:0]     b;
    logic [ACCW-1:0] es;
    reset = 1'b1; start_s = 1'b0; ready_s = 1'b0; sel = 1'b0; ones_mode = 1'b0; bits = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_req0", req0, 1'b0);
    chk("rst_seg0", seg0, 3'd0);
    chk("rst_din0", din0, 5'd0);
    chk("rst_valid0", val0, 1'b0);
    chk("rst_sum0", sum0, '0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_valid1", val1, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    b = '0;
    for (int i = 0; i < 8; i++) b[i*5 +: 5] = 5'(i + 1);
    run_job(b, 10, ACCW'(36), 5, 1'b0, 1'b0);

    ones_mode = 1'b1;
    es = '1;
    es[2:0] = 3'b000;
    run_job({40{1'b1}}, 10, es, 0, 1'b0, 1'b0);
    ones_mode = 1'b0;

    bits = b; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_req", req0, 1'b0);
    chk("rst_mid_valid", val0, 1'b0);
    chk("rst_mid_sum", sum0, '0);
    run_job({8{5'd2}}, 10, ACCW'(16), 0, 1'b0, 1'b0);

    sel = 1'b1;
    @(negedge clk);
    run_job(b, 12, ACCW'(36), 0, 1'b1, 1'b0);
    sel = 1'b0;
    @(negedge clk);

    b = '0;
    b[10 +: 5] = 5'd3;
    b[25 +: 5] = 5'd7;
    run_job(b, SKIP ? 4 : 10, ACCW'(10), 0, 1'b0, SKIP);
    run_job(40'd0, SKIP ? 3 : 10, ACCW'(0), 0, 1'b0, SKIP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
